// File: rtl/spike_noc_pkg.sv
// Shared definitions for the spike network-on-chip: address width and emitter state encoding.
package spike_noc_pkg;

  localparam int SRC_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } emit_state_t;

  // Index width for a vector of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_priority_encoder.sv
// Combinational lowest-set-bit encoder over the pending spike vector.
module spike_priority_encoder
  import spike_noc_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_WIDTH   = idx_width(NUM_NEURONS)
) (
  input  logic [NUM_NEURONS-1:0] vec,
  output logic                   found,
  output logic [IDX_WIDTH-1:0]   index
);

  // Scanning from the top down lets the lowest set bit overwrite the others.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        index = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/spike_address_emitter.sv
// Captures a cluster's fired-neuron vector at timestep end and streams one
// source address per handshake, lowest index first, then pulses clear.
module spike_address_emitter
  import spike_noc_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_WIDTH  = SRC_ADDR_WIDTH,
  parameter int CNT_WIDTH   = $clog2(NUM_NEURONS + 1)
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  base_address,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  input  logic                   timestep_end,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic [ADDR_WIDTH-1:0]  src_address,
  output logic                   clear,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   spike_count,
  output logic                   overrun
);

  localparam int IDX_WIDTH = idx_width(NUM_NEURONS);

  emit_state_t            state, next_state;
  logic [NUM_NEURONS-1:0] pending, next_pending;
  logic [ADDR_WIDTH-1:0]  base_reg, next_base;
  logic [CNT_WIDTH-1:0]   run_cnt;
  logic                   capture;
  logic                   handshake;
  logic                   enc_found;
  logic [IDX_WIDTH-1:0]   enc_index;

  assign handshake = src_valid & src_ready;
  assign clear     = (state == DONE);
  assign busy      = (state != IDLE);

  // The encoder looks at the vector as it will be next cycle so that the
  // registered address is ready the cycle after capture or acceptance.
  spike_priority_encoder #(
    .NUM_NEURONS(NUM_NEURONS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_encoder (
    .vec  (next_pending),
    .found(enc_found),
    .index(enc_index)
  );

  always_comb begin
    next_state   = state;
    next_pending = pending;
    next_base    = base_reg;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (timestep_end) begin
          capture      = 1'b1;
          next_pending = spikes_in;
          next_base    = base_address;
          next_state   = SEND;
        end
      end
      SEND: begin
        if (pending == '0) begin
          next_state = DONE;
        end else if (handshake) begin
          // Drops the lowest set bit, which is the one just accepted.
          next_pending = pending & (pending - NUM_NEURONS'(1));
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      base_reg    <= '0;
      run_cnt     <= '0;
      src_valid   <= 1'b0;
      src_address <= '0;
      spike_count <= '0;
      overrun     <= 1'b0;
    end else begin
      state    <= next_state;
      pending  <= next_pending;
      base_reg <= next_base;
      src_valid <= (next_state == SEND) && enc_found;
      if ((next_state == SEND) && enc_found) begin
        src_address <= next_base + ADDR_WIDTH'(enc_index);
      end
      if (capture) begin
        run_cnt <= '0;
      end else if ((state == SEND) && handshake) begin
        run_cnt <= run_cnt + CNT_WIDTH'(1);
      end
      if (state == DONE) begin
        spike_count <= run_cnt;
      end
      if (timestep_end && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_address_emitter.sv
// Directed self-checking bench for spike_address_emitter.
module tb_spike_address_emitter;

  logic        CLK;
  logic        rst_n;
  logic [11:0] base_address;
  logic [9:0]  spikes_in;
  logic        timestep_end;
  logic        src_valid;
  logic        src_ready;
  logic [11:0] src_address;
  logic        clear;
  logic        busy;
  logic [3:0]  spike_count;
  logic        overrun;

  int checkCount = 0;
  int passCount  = 0;
  logic [11:0] expAddrs[$];

  spike_address_emitter dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .base_address(base_address),
    .spikes_in   (spikes_in),
    .timestep_end(timestep_end),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_address (src_address),
    .clear       (clear),
    .busy        (busy),
    .spike_count (spike_count),
    .overrun     (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Strobes timestep_end for one cycle, then scrambles inputs to prove they were sampled.
  task automatic applyStimulus(input logic [11:0] base, input logic [9:0] spikes);
    base_address = base;
    spikes_in    = spikes;
    timestep_end = 1'b1;
    src_ready    = 1'b1;
    checkOutput("idle_busy", 32'(busy), 0);
    tick();
    timestep_end = 1'b0;
    spikes_in    = '0;
    base_address = 12'hABC;
  endtask

  // Expects the addresses in expAddrs on consecutive cycles, optionally stalling the first.
  task automatic expectStream(input string tag, input int stall, input int expCount);
    for (int i = 0; i < expAddrs.size(); i++) begin
      if (i == 0 && stall > 0) begin
        src_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          checkOutput({tag, "_stall_valid"}, 32'(src_valid), 1);
          checkOutput({tag, "_stall_addr"}, 32'(src_address), 32'(expAddrs[0]));
          checkOutput({tag, "_stall_clear"}, 32'(clear), 0);
          tick();
        end
        src_ready = 1'b1;
      end
      checkOutput({tag, "_valid"}, 32'(src_valid), 1);
      checkOutput({tag, "_addr"}, 32'(src_address), 32'(expAddrs[i]));
      tick();
    end
    checkOutput({tag, "_tail_valid"}, 32'(src_valid), 0);
    checkOutput({tag, "_tail_clear"}, 32'(clear), 0);
    checkOutput({tag, "_tail_busy"}, 32'(busy), 1);
    tick();
    checkOutput({tag, "_clear"}, 32'(clear), 1);
    checkOutput({tag, "_clear_busy"}, 32'(busy), 1);
    checkOutput({tag, "_clear_valid"}, 32'(src_valid), 0);
    tick();
    checkOutput({tag, "_after_clear"}, 32'(clear), 0);
    checkOutput({tag, "_after_busy"}, 32'(busy), 0);
    checkOutput({tag, "_count"}, 32'(spike_count), 32'(expCount));
  endtask

  initial begin
    rst_n        = 1'b0;
    timestep_end = 1'b0;
    spikes_in    = '0;
    base_address = '0;
    src_ready    = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(src_valid), 0);
    checkOutput("rst_addr", 32'(src_address), 0);
    checkOutput("rst_clear", 32'(clear), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_count", 32'(spike_count), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    #20 rst_n = 1'b1;
    tick();

    $display("[TB] basic emission");
    expAddrs.delete();
    expAddrs.push_back(12'h100);
    expAddrs.push_back(12'h102);
    expAddrs.push_back(12'h105);
    applyStimulus(12'h100, 10'b0000100101);
    expectStream("basic", 0, 3);
    checkOutput("basic_overrun", 32'(overrun), 0);

    $display("[TB] empty vector");
    expAddrs.delete();
    applyStimulus(12'h123, 10'b0000000000);
    expectStream("empty", 0, 0);

    $display("[TB] backpressure");
    expAddrs.delete();
    expAddrs.push_back(12'h010);
    expAddrs.push_back(12'h019);
    applyStimulus(12'h010, 10'b1000000001);
    expectStream("stall", 4, 2);

    $display("[TB] wrap-around full vector");
    expAddrs.delete();
    expAddrs.push_back(12'hFFE);
    expAddrs.push_back(12'hFFF);
    expAddrs.push_back(12'h000);
    expAddrs.push_back(12'h001);
    expAddrs.push_back(12'h002);
    expAddrs.push_back(12'h003);
    expAddrs.push_back(12'h004);
    expAddrs.push_back(12'h005);
    expAddrs.push_back(12'h006);
    expAddrs.push_back(12'h007);
    applyStimulus(12'hFFE, 10'h3FF);
    expectStream("wrap", 0, 10);
    checkOutput("wrap_overrun", 32'(overrun), 0);

    $display("[TB] overrun");
    applyStimulus(12'h200, 10'b0000000011);
    checkOutput("ovr_addr0", 32'(src_address), 32'h200);
    base_address = 12'h300;
    spikes_in    = 10'h3FF;
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    checkOutput("ovr_flag", 32'(overrun), 1);
    checkOutput("ovr_addr1", 32'(src_address), 32'h201);
    checkOutput("ovr_valid1", 32'(src_valid), 1);
    tick();
    checkOutput("ovr_tail_valid", 32'(src_valid), 0);
    checkOutput("ovr_tail_clear", 32'(clear), 0);
    tick();
    checkOutput("ovr_clear", 32'(clear), 1);
    tick();
    checkOutput("ovr_after_clear", 32'(clear), 0);
    checkOutput("ovr_count", 32'(spike_count), 2);
    tick();
    checkOutput("ovr_no_recapture_busy", 32'(busy), 0);
    checkOutput("ovr_no_recapture_valid", 32'(src_valid), 0);
    checkOutput("ovr_sticky", 32'(overrun), 1);

    $display("[TB] mid-emission reset");
    applyStimulus(12'h040, 10'b0000001010);
    checkOutput("mrst_addr0", 32'(src_address), 32'h041);
    tick();
    checkOutput("mrst_addr1", 32'(src_address), 32'h043);
    checkOutput("mrst_valid1", 32'(src_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid", 32'(src_valid), 0);
    checkOutput("mrst_addr", 32'(src_address), 0);
    checkOutput("mrst_busy", 32'(busy), 0);
    checkOutput("mrst_clear", 32'(clear), 0);
    checkOutput("mrst_count", 32'(spike_count), 0);
    checkOutput("mrst_overrun", 32'(overrun), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("mrst_hold_clear", 32'(clear), 0);
    end
    #3 rst_n = 1'b1;
    tick();
    checkOutput("mrst_idle_busy", 32'(busy), 0);
    checkOutput("mrst_idle_valid", 32'(src_valid), 0);
    checkOutput("mrst_idle_clear", 32'(clear), 0);

    expAddrs.delete();
    expAddrs.push_back(12'h7F8);
    applyStimulus(12'h7F0, 10'b0100000000);
    expectStream("post_reset", 0, 1);
    checkOutput("post_reset_overrun", 32'(overrun), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
